// File: rtl/binary_divider_seq_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master drives requests and operands. The slave (divider) returns status and results.
interface binary_divider_seq_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/binary_divider_seq.sv
// Restoring shift-subtract unsigned divider that resolves one quotient bit per clock.
// It uses a start/busy/done handshake. A zero divisor short-circuits to a one-cycle completion.
module binary_divider_seq #(
    parameter int WIDTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    binary_divider_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DZ, FIN} state_t;

    state_t           r_state;
    state_t           w_nextState;
    state_t           w_startState;
    logic [WIDTH-1:0] r_dividendSh;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_partRem;
    logic [WIDTH-1:0] r_quoSh;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_divByZero;

    logic             w_accept;
    logic             w_lastIter;
    logic             w_ge;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_nextRem;
    logic [WIDTH-1:0] w_nextQuo;

    assign w_accept     = bus.start && ((r_state == IDLE) || (r_state == FIN));
    assign w_startState = (bus.divisor == '0) ? DZ : RUN;
    assign w_lastIter   = (r_count == CW'(1));

    // The partial remainder always stays below the divisor.
    // The shifted value is therefore under twice the divisor, and the sign of the WIDTH+1-bit difference is a clean borrow.
    assign w_shifted = {r_partRem, r_dividendSh[WIDTH-1]};
    assign w_diff    = w_shifted - {1'b0, r_divisor};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_nextRem = w_ge ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign w_nextQuo = (r_quoSh << 1) | {{(WIDTH-1){1'b0}}, w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_nextState = w_startState;
            RUN:     if (w_lastIter) w_nextState = FIN;
            DZ:      w_nextState = FIN;
            FIN:     w_nextState = bus.start ? w_startState : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Working registers advance only in RUN. Result registers change only at a completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dividendSh <= '0;
            r_divisor    <= '0;
            r_partRem    <= '0;
            r_quoSh      <= '0;
            r_count      <= '0;
            r_quotient   <= '0;
            r_remainder  <= '0;
            r_divByZero  <= 1'b0;
        end else if (w_accept) begin
            r_dividendSh <= bus.dividend;
            r_divisor    <= bus.divisor;
            r_partRem    <= '0;
            r_quoSh      <= '0;
            r_count      <= CW'(WIDTH);
        end else if (r_state == RUN) begin
            r_dividendSh <= r_dividendSh << 1;
            r_partRem    <= w_nextRem;
            r_quoSh      <= w_nextQuo;
            r_count      <= r_count - 1'b1;
            if (w_lastIter) begin
                r_quotient  <= w_nextQuo;
                r_remainder <= w_nextRem;
                r_divByZero <= 1'b0;
            end
        end else if (r_state == DZ) begin
            r_quotient  <= '1;
            r_remainder <= r_dividendSh;
            r_divByZero <= 1'b1;
        end
    end

    assign bus.busy        = (r_state == RUN) || (r_state == DZ);
    assign bus.done        = (r_state == FIN);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_divByZero;
endmodule

// File: tb/tb_binary_divider_seq.sv
// Self-checking bench for binary_divider_seq.
// It compares directed, exhaustive and random divisions against a plain-arithmetic reference model.
module tb_binary_divider_seq;
    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   passCount  = 0;
    int   prevQ      = 0;
    int   prevR      = 0;

    binary_divider_seq_if #(.WIDTH(WIDTH)) divIf ();

    binary_divider_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (divIf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    // Reference model: plain integer division, with the zero-divisor convention.
    task automatic modelDiv(input int a, input int b, output int q, output int r,
                            output int dz, output int lat);
        if (b == 0) begin
            q = MAXV; r = a; dz = 1; lat = 1;
        end else begin
            q = a / b; r = a % b; dz = 0; lat = WIDTH;
        end
    endtask

    // Count edges until done appears. Results must hold and busy must stay high meanwhile.
    task automatic waitDone(input string tag, output int edges);
        edges = 0;
        while (divIf.done !== 1'b1 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (divIf.done !== 1'b1) begin
                checkOutput({tag, "/busy"}, int'(divIf.busy), 1);
                checkOutput({tag, "/qHold"}, int'(divIf.quotient), prevQ);
                checkOutput({tag, "/rHold"}, int'(divIf.remainder), prevR);
            end
        end
    endtask

    task automatic checkResult(input string tag, input int a, input int b, input int edges);
        int q, r, dz, lat;
        modelDiv(a, b, q, r, dz, lat);
        checkOutput({tag, "/latency"}, edges, lat);
        checkOutput({tag, "/quotient"}, int'(divIf.quotient), q);
        checkOutput({tag, "/remainder"}, int'(divIf.remainder), r);
        checkOutput({tag, "/dz"}, int'(divIf.div_by_zero), dz);
        checkOutput({tag, "/busyAtDone"}, int'(divIf.busy), 0);
        if (b != 0) begin
            checkOutput({tag, "/invariant"},
                        int'(divIf.quotient) * b + int'(divIf.remainder), a);
            checkOutput({tag, "/remLtDiv"}, int'(int'(divIf.remainder) < b), 1);
        end
        prevQ = q;
        prevR = r;
    endtask

    // Issue one operation from an idle slot, scramble operands after accept, check everything.
    task automatic applyStimulus(input int a, input int b, input string tag);
        int edges;
        divIf.start    = 1'b1;
        divIf.dividend = WIDTH'(a);
        divIf.divisor  = WIDTH'(b);
        @(posedge clk); #1;
        divIf.start    = 1'b0;
        divIf.dividend = WIDTH'($urandom_range(0, MAXV));
        divIf.divisor  = WIDTH'($urandom_range(0, MAXV));
        checkOutput({tag, "/busyAccept"}, int'(divIf.busy), 1);
        waitDone(tag, edges);
        checkResult(tag, a, b, edges);
        @(posedge clk); #1;
        checkOutput({tag, "/donePulse"}, int'(divIf.done), 0);
    endtask

    initial begin
        int e1, e2, doneSeen;

        rst            = 1'b1;
        divIf.start    = 1'b0;
        divIf.dividend = '0;
        divIf.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset/busy", int'(divIf.busy), 0);
        checkOutput("reset/done", int'(divIf.done), 0);
        checkOutput("reset/quotient", int'(divIf.quotient), 0);
        checkOutput("reset/remainder", int'(divIf.remainder), 0);
        checkOutput("reset/dz", int'(divIf.div_by_zero), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(13, 3, "13/3");
        applyStimulus(15, 1, "15/1");
        applyStimulus(2, 7, "2/7");
        applyStimulus(0, 5, "0/5");
        applyStimulus(15, 15, "15/15");
        applyStimulus(9, 0, "9/0");
        applyStimulus(8, 2, "8/2");

        // Start held high through RUN with operands changed mid-run, then back-to-back in FIN.
        divIf.start    = 1'b1;
        divIf.dividend = WIDTH'(6);
        divIf.divisor  = WIDTH'(4);
        @(posedge clk); #1;
        divIf.dividend = WIDTH'(9);
        divIf.divisor  = WIDTH'(2);
        waitDone("b2b1", e1);
        checkResult("b2b1", 6, 4, e1);
        @(posedge clk); #1;
        divIf.start = 1'b0;
        checkOutput("b2b2/busyAccept", int'(divIf.busy), 1);
        waitDone("b2b2", e2);
        checkOutput("b2b/spacing", e2 + 1, WIDTH + 1);
        checkResult("b2b2", 9, 2, e2);
        @(posedge clk); #1;
        checkOutput("b2b2/donePulse", int'(divIf.done), 0);

        // Asynchronous reset between edges during the second RUN cycle.
        divIf.start    = 1'b1;
        divIf.dividend = WIDTH'(11);
        divIf.divisor  = WIDTH'(2);
        @(posedge clk); #1;
        divIf.start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkOutput("midReset/busy", int'(divIf.busy), 0);
        checkOutput("midReset/done", int'(divIf.done), 0);
        checkOutput("midReset/quotient", int'(divIf.quotient), 0);
        checkOutput("midReset/remainder", int'(divIf.remainder), 0);
        checkOutput("midReset/dz", int'(divIf.div_by_zero), 0);
        #2;
        rst   = 1'b0;
        prevQ = 0;
        prevR = 0;
        doneSeen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (divIf.done === 1'b1) doneSeen++;
        end
        checkOutput("midReset/noDone", doneSeen, 0);
        applyStimulus(11, 2, "11/2 afterReset");

        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 0; b <= MAXV; b++) begin
                applyStimulus(a, b, $sformatf("sweep %0d/%0d", a, b));
            end
        end

        for (int i = 0; i < 60; i++) begin
            int ra, rb;
            ra = $urandom_range(0, MAXV);
            rb = $urandom_range(0, MAXV);
            applyStimulus(ra, rb, $sformatf("rand %0d/%0d", ra, rb));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
